load_store_unit: RTL and testbench

Load/store unit between the core's memory stage and the byte-addressable data RAM. Takes one RISC-V load or store per request (funct3 encoding) and produces word-aligned RAM accesses: combinational-read lane extraction with sign/zero extension for loads, and read-modify-write for byte and halfword stores. The RAM has no byte enables, so every sub-word store is a two-access sequence. Misaligned and illegal requests are rejected without touching memory.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: turns one RISC-V load/store request into word-aligned RAM
// accesses. Loads read one word and extract/extend the addressed lane. Byte
// and halfword stores are done as read-modify-write because the RAM has no
// byte enables. Misaligned and illegal requests finish without touching RAM.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;         // addr[1:0] of the request in flight
  logic [15:0] wdata_q, wdata_d;       // only the sub-word store data is needed later
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic        can_accept;
  logic        illegal;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Request decode on the live inputs: illegal encodings and misalignment.
  always_comb begin
    if (we) illegal = (funct3 >= 3'b011);
    else    illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  // Lane extraction plus sign/zero extension, and store merge into the read word.
  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // Next-state logic; RAM strobes are computed here so they leave as flop outputs.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    // The edge that ends a done cycle can already take the next request.
    can_accept  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);

    case (state_q)
      S_RD: begin
        if (we_q) begin
          mem_wdata_d = merged;
          mem_write_d = 1'b1;
          state_d     = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        rdata_d = 32'd0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (can_accept && req) begin
      we_d       = we;
      funct3_d   = funct3;
      lane_d     = addr[1:0];
      wdata_d    = wdata[15:0];
      mem_addr_d = {addr[31:2], 2'b00};
      if (illegal || misaligned) begin
        rdata_d = 32'd0;
        state_d = S_ERR;
      end else if (we && (funct3 == 3'b010)) begin
        mem_wdata_d = wdata;
        mem_write_d = 1'b1;
        state_d     = S_WR;
      end else begin
        mem_read_d = 1'b1;
        state_d    = S_RD;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 16'd0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) || (state_q == S_ERR);
  assign err       = (state_q == S_ERR);
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word RAM model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram [0:255];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = ram[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to done. Cycle k is the cycle after accept edge + (k-1).
  task automatic run(input string name, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_done, input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_wr_cyc, input logic [31:0] exp_wr_data, input int exp_rd_cnt);
    int done_cyc = 0, wr_cnt = 0, wr_cyc = 0, rd_cnt = 0;
    logic [31:0] wr_data = 32'd0, r = 32'hx;
    logic e = 1'bx;
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_write) begin wr_cnt++; wr_cyc = k; wr_data = mem_wdata; end
      if (mem_read) rd_cnt++;
      if (done) begin done_cyc = k; r = rdata; e = err; break; end
      @(posedge clk); #1;
    end
    $display("txn %s we=%0b f3=%0d addr=%h done_cyc=%0d rdata=%h err=%0b wr_cnt=%0d wdata=%h",
             name, w, f3, a, done_cyc, r, e, wr_cnt, wr_data);
    chk({name, ".done_cyc"}, done_cyc, exp_done);
    chk({name, ".rdata"}, r, exp_rdata);
    chk({name, ".err"}, {31'd0, e}, {31'd0, exp_err});
    chk({name, ".wr_cnt"}, wr_cnt, (exp_wr_cyc != 0) ? 1 : 0);
    chk({name, ".rd_cnt"}, rd_cnt, exp_rd_cnt);
    if (exp_wr_cyc != 0) begin
      chk({name, ".wr_cyc"}, wr_cyc, exp_wr_cyc);
      chk({name, ".wr_data"}, wr_data, exp_wr_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    ram[64] = 32'h8899AABB;
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Loads: name, we, f3, addr, wdata, done, rdata, err, wr_cyc, wr_data, rd_cnt
    run("LW100",  1'b0, 3'b010, 32'h100, 32'd0, 2, 32'h8899AABB, 1'b0, 0, 32'd0, 1);
    run("LB103",  1'b0, 3'b000, 32'h103, 32'd0, 2, 32'hFFFFFF88, 1'b0, 0, 32'd0, 1);
    run("LBU103", 1'b0, 3'b100, 32'h103, 32'd0, 2, 32'h00000088, 1'b0, 0, 32'd0, 1);
    run("LH102",  1'b0, 3'b001, 32'h102, 32'd0, 2, 32'hFFFF8899, 1'b0, 0, 32'd0, 1);
    run("LHU100", 1'b0, 3'b101, 32'h100, 32'd0, 2, 32'h0000AABB, 1'b0, 0, 32'd0, 1);
    run("LB101",  1'b0, 3'b000, 32'h101, 32'd0, 2, 32'hFFFFFFAA, 1'b0, 0, 32'd0, 1);

    // Sub-word stores: read-modify-write, write in cycle N+2
    run("SB101",  1'b1, 3'b000, 32'h101, 32'h00000055, 3, 32'd0, 1'b0, 2, 32'h889955BB, 1);
    run("LW100b", 1'b0, 3'b010, 32'h100, 32'd0, 2, 32'h889955BB, 1'b0, 0, 32'd0, 1);
    @(negedge clk); ram[64] = 32'h8899AABB;
    run("SH102",  1'b1, 3'b001, 32'h102, 32'hFFFF1234, 3, 32'd0, 1'b0, 2, 32'h1234AABB, 1);
    run("LW100c", 1'b0, 3'b010, 32'h100, 32'd0, 2, 32'h1234AABB, 1'b0, 0, 32'd0, 1);

    // Full-word store: write only in N+1
    run("SW104",  1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 2, 32'd0, 1'b0, 1, 32'hDEADBEEF, 0);
    run("LBU106", 1'b0, 3'b100, 32'h106, 32'd0, 2, 32'h000000AD, 1'b0, 0, 32'd0, 1);

    // Error cases: done+err at N+1, rdata cleared, no RAM access
    run("E_LW102", 1'b0, 3'b010, 32'h102, 32'd0, 1, 32'd0, 1'b1, 0, 32'd0, 0);
    run("LW104",   1'b0, 3'b010, 32'h104, 32'd0, 2, 32'hDEADBEEF, 1'b0, 0, 32'd0, 1);
    run("E_SH101", 1'b1, 3'b001, 32'h101, 32'h1111, 1, 32'd0, 1'b1, 0, 32'd0, 0);
    run("E_L011",  1'b0, 3'b011, 32'h100, 32'd0, 1, 32'd0, 1'b1, 0, 32'd0, 0);
    run("E_S100",  1'b1, 3'b100, 32'h100, 32'h2222, 1, 32'd0, 1'b1, 0, 32'd0, 0);
    chk("E.ram_untouched", ram[64], 32'h1234AABB);

    // Reset during the WR cycle of an SB
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h108; wdata = 32'h77;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    chk("rstwr.mem_write_before", {31'd0, mem_write}, 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    $display("txn RSTWR busy=%0b mem_write=%0b done=%0b", busy, mem_write, done);
    chk("rstwr.busy", {31'd0, busy}, 32'd0);
    chk("rstwr.mem_write", {31'd0, mem_write}, 32'd0);
    chk("rstwr.done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Back-to-back LW then SW with req held high
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h104; wdata = 32'd0;
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h10C; wdata = 32'hCAFEF00D;
    chk("b2b.rd_cycle", {30'd0, busy, mem_read}, 32'd3);
    @(posedge clk); #1;
    chk("b2b.lw_done", {31'd0, done}, 32'd1);
    chk("b2b.lw_rdata", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    req = 1'b0;
    chk("b2b.sw_accept", {29'd0, busy, done, mem_write}, 32'd5);
    chk("b2b.sw_wdata", mem_wdata, 32'hCAFEF00D);
    chk("b2b.sw_addr", mem_addr, 32'h10C);
    @(posedge clk); #1;
    chk("b2b.sw_done", {30'd0, done, mem_write}, 32'd2);
    chk("b2b.ram", ram[67], 32'hCAFEF00D);
    $display("txn B2B lw_then_sw ram10C=%h", ram[67]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
